// File: rtl/div_unpack.sv
// div_unpack: front end of the floating-point divider.
// Decodes two raw IEEE-754 operands (double or single), classifies them,
// normalizes denormal significands one bit per cycle and presents aligned
// 53-bit significands, the quotient sign and the unbiased exponent difference.
module div_unpack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        db_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [52:0] fa,
    output logic [52:0] fb,
    output logic        db,
    output logic        sq,
    output logic [12:0] eq,
    output logic        a_zero,
    output logic        a_inf,
    output logic        a_nan,
    output logic        b_zero,
    output logic        b_inf,
    output logic        b_nan
);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t     state;
    logic       capture;
    logic [1:0] need_norm;
    logic [1:0] norm_next;
    logic       any_flag_in;
    logic       any_flag;

    assign capture   = (state == IDLE) && in_valid;
    assign in_ready  = (state == IDLE);
    assign any_flag  = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;

    // Per-operand decode and normalization datapath; operand 0 is a, 1 is b.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            logic [63:0] x;
            logic [10:0] dexp;
            logic [51:0] dfrac;
            logic [7:0]  sexp;
            logic [22:0] sfrac;
            logic        ld_sign;
            logic        ld_zero;
            logic        ld_inf;
            logic        ld_nan;
            logic        ld_special;
            logic [52:0] ld_sig;
            logic [12:0] ld_exp;
            logic [52:0] sig_reg;
            logic [12:0] exp_reg;
            logic        special_reg;
            logic        shift_en;
            logic [52:0] sig_next;
            logic [12:0] exp_next;

            assign x     = (gi == 0) ? a : b;
            assign dexp  = x[62:52];
            assign dfrac = x[51:0];
            assign sexp  = x[30:23];
            assign sfrac = x[22:0];

            // Field extraction and classification for the selected format.
            always_comb begin
                ld_sign = 1'b0;
                ld_zero = 1'b0;
                ld_inf  = 1'b0;
                ld_nan  = 1'b0;
                ld_sig  = '0;
                ld_exp  = '0;
                if (db_in) begin
                    ld_sign = x[63];
                    ld_zero = (dexp == 11'd0) && (dfrac == 52'd0);
                    ld_inf  = (dexp == 11'h7FF) && (dfrac == 52'd0);
                    ld_nan  = (dexp == 11'h7FF) && (dfrac != 52'd0);
                    ld_sig  = {(dexp != 11'd0), dfrac};
                    // Denormals share the exponent of the smallest normal.
                    ld_exp  = (dexp != 11'd0) ? ({2'b00, dexp} - 13'd1023)
                                              : (13'd1 - 13'd1023);
                end else begin
                    ld_sign = x[31];
                    ld_zero = (sexp == 8'd0) && (sfrac == 23'd0);
                    ld_inf  = (sexp == 8'hFF) && (sfrac == 23'd0);
                    ld_nan  = (sexp == 8'hFF) && (sfrac != 23'd0);
                    ld_sig  = {(sexp != 8'd0), sfrac, 29'd0};
                    ld_exp  = (sexp != 8'd0) ? ({5'b00000, sexp} - 13'd127)
                                             : (13'd1 - 13'd127);
                end
            end

            assign ld_special = ld_zero | ld_inf | ld_nan;
            assign need_norm[gi] = !ld_special && !ld_sig[52];

            // One normalization step: shift only finite non-zero operands still lacking a leading one.
            assign shift_en  = !special_reg && !sig_reg[52];
            assign sig_next  = shift_en ? {sig_reg[51:0], 1'b0} : sig_reg;
            assign exp_next  = shift_en ? (exp_reg - 13'd1) : exp_reg;
            assign norm_next[gi] = special_reg || sig_next[52];

            // Working significand/exponent: loaded at capture, stepped while normalizing.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sig_reg     <= '0;
                    exp_reg     <= '0;
                    special_reg <= 1'b0;
                end else if (capture) begin
                    sig_reg     <= ld_sig;
                    exp_reg     <= ld_exp;
                    special_reg <= ld_special;
                end else if (state == NORM) begin
                    sig_reg <= sig_next;
                    exp_reg <= exp_next;
                end
            end
        end
    endgenerate

    assign any_flag_in = g_op[0].ld_special | g_op[1].ld_special;

    // Control FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            fa        <= '0;
            fb        <= '0;
            db        <= 1'b0;
            sq        <= 1'b0;
            eq        <= '0;
            a_zero    <= 1'b0;
            a_inf     <= 1'b0;
            a_nan     <= 1'b0;
            b_zero    <= 1'b0;
            b_inf     <= 1'b0;
            b_nan     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        db     <= db_in;
                        sq     <= g_op[0].ld_sign ^ g_op[1].ld_sign;
                        a_zero <= g_op[0].ld_zero;
                        a_inf  <= g_op[0].ld_inf;
                        a_nan  <= g_op[0].ld_nan;
                        b_zero <= g_op[1].ld_zero;
                        b_inf  <= g_op[1].ld_inf;
                        b_nan  <= g_op[1].ld_nan;
                        // Loaded values are final unless a denormal needs normalizing
                        // with no special operand present.
                        fa     <= g_op[0].ld_sig;
                        fb     <= g_op[1].ld_sig;
                        eq     <= any_flag_in ? 13'd0 : (g_op[0].ld_exp - g_op[1].ld_exp);
                        if (|need_norm) begin
                            state <= NORM;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                NORM: begin
                    // Leave on the edge whose shift completes normalization.
                    if (&norm_next) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        if (!any_flag) begin
                            fa <= g_op[0].sig_next;
                            fb <= g_op[1].sig_next;
                            eq <= g_op[0].exp_next - g_op[1].exp_next;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unpack.sv
// Directed bench for div_unpack: drives operand pairs, keeps expected results
// in a queue, and compares each result, its latency and the handshake behaviour.
module tb_div_unpack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        db_in;
    logic        out_valid;
    logic        out_ready;
    logic [52:0] fa;
    logic [52:0] fb;
    logic        db;
    logic        sq;
    logic [12:0] eq;
    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

    typedef struct {
        logic [52:0] fa;
        logic [52:0] fb;
        logic [12:0] eq;
        logic        sq;
        logic        db;
        logic [5:0]  flags;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    div_unpack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .db_in     (db_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fa        (fa),
        .fb        (fb),
        .db        (db),
        .sq        (sq),
        .eq        (eq),
        .a_zero    (a_zero),
        .a_inf     (a_inf),
        .a_nan     (a_nan),
        .b_zero    (b_zero),
        .b_inf     (b_inf),
        .b_nan     (b_nan)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic push(input logic [52:0] efa, input logic [52:0] efb, input int eeq,
                        input logic esq, input logic edb, input logic [5:0] eflags, input int elat);
        exp_t e;
        e.fa    = efa;
        e.fb    = efb;
        e.eq    = 13'(eeq);
        e.sq    = esq;
        e.db    = edb;
        e.flags = eflags;
        e.lat   = elat;
        sb.push_back(e);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".fa"},    64'(fa), 64'(cur.fa));
        check({tag, ".fb"},    64'(fb), 64'(cur.fb));
        check({tag, ".eq"},    64'(eq), 64'(cur.eq));
        check({tag, ".sq"},    64'(sq), 64'(cur.sq));
        check({tag, ".db"},    64'(db), 64'(cur.db));
        check({tag, ".flags"}, 64'({a_zero, a_inf, a_nan, b_zero, b_inf, b_nan}), 64'(cur.flags));
    endtask

    // Offer one operand pair, wait for the result, compare it, hold it for
    // 'hold' cycles of backpressure, then release it.
    task automatic do_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                         input logic tdb, input int hold);
        int n;
        @(negedge clk);
        a        = ta;
        b        = tb_v;
        db_in    = tdb;
        in_valid = 1'b1;
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) begin
            check({tag, ".timeout"}, 64'(out_valid), 64'd1);
        end else if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            cur = sb.pop_front();
            $display("%s: latency %0d fa=%h fb=%h eq=%0d sq=%0b db=%0b", tag, n, fa, fb,
                     $signed(eq), sq, db);
            check({tag, ".latency"}, 64'(n), 64'(cur.lat));
            check_outputs(tag);
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
                check({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
                check_outputs({tag, ".hold"});
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check({tag, ".rel_valid"}, 64'(out_valid), 64'd0);
            check({tag, ".rel_ready"}, 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        db_in     = 1'b0;
        #1;
        check("reset.in_ready",  64'(in_ready), 64'd1);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.fa",        64'(fa), 64'd0);
        check("reset.eq",        64'(eq), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 6.0 / 2.0 double
        push(53'h18000000000000, 53'h10000000000000, 1, 1'b0, 1'b1, 6'b000000, 1);
        do_op("dbl_6_2", 64'h4018000000000000, 64'h4000000000000000, 1'b1, 0);

        // smallest double denormal / 1.0: 52 shifts
        push(53'h10000000000000, 53'h10000000000000, -1074, 1'b0, 1'b1, 6'b000000, 53);
        do_op("dbl_denorm", 64'h0000000000000001, 64'h3FF0000000000000, 1'b1, 0);

        // single 1.0 / -2.0 with junk in the ignored upper half
        push(53'h10000000000000, 53'h10000000000000, -1, 1'b1, 1'b0, 6'b000000, 1);
        do_op("sgl_1_m2", 64'hDEADBEEF3F800000, 64'h12345678C0000000, 1'b0, 0);

        // zero / NaN with 5 cycles of backpressure
        push(53'h00000000000000, 53'h18000000000000, 0, 1'b0, 1'b1, 6'b100001, 1);
        do_op("zero_nan", 64'h0000000000000000, 64'h7FF8000000000000, 1'b1, 5);

        // smallest single denormal / 1.0: 23 shifts
        push(53'h10000000000000, 53'h10000000000000, -149, 1'b0, 1'b0, 6'b000000, 24);
        do_op("sgl_denorm", 64'h0000000000000001, 64'h000000003F800000, 1'b0, 0);

        // -inf / 1.0 double
        push(53'h10000000000000, 53'h10000000000000, 0, 1'b1, 1'b1, 6'b010000, 1);
        do_op("ninf_1", 64'hFFF0000000000000, 64'h3FF0000000000000, 1'b1, 0);

        // Reset during normalization: result must vanish without a handshake.
        @(negedge clk);
        a        = 64'h0000000000000001;
        b        = 64'h3FF0000000000000;
        db_in    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort.out_valid", 64'(out_valid), 64'd0);
        check("abort.in_ready",  64'(in_ready), 64'd1);
        check("abort.fa",        64'(fa), 64'd0);
        check("abort.fb",        64'(fb), 64'd0);
        check("abort.eq",        64'(eq), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        $display("abort: out_valid pulses after reset = %0d", seen);
        check("abort.no_valid", 64'(seen), 64'd0);

        // Recovery after the aborted operation.
        push(53'h18000000000000, 53'h10000000000000, 1, 1'b0, 1'b1, 6'b000000, 1);
        do_op("recover", 64'h4018000000000000, 64'h4000000000000000, 1'b1, 0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
